lock_supervisor: RTL and testbench



---
 rtl/lock_supervisor.sv | 166 ++++++++++++++++
 tb/tb_lock_supervisor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lock_supervisor.sv
// lock_supervisor: downstream supervisor for the keypad padlock FSM.
// Turns the padlock's unlock/err flags into a timed door-relay window,
// counts failed entries, enforces a timed lockout with alarm after too
// many failures, and generates the relock reset request for the padlock.
module lock_supervisor #(
   parameter int unsigned OPEN_CYCLES    = 8,   // relay-on clocks per unlock (1..2^TMR_W)
   parameter int unsigned LOCKOUT_CYCLES = 16,  // lockout clocks (1..2^TMR_W)
   parameter int unsigned MAX_FAILS      = 3,   // failures that trigger lockout (1..2^FAIL_W-1)
   parameter int unsigned TMR_W          = 8,
   parameter int unsigned FAIL_W         = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              unlock,
   input  logic              err,
   output logic              relay,
   output logic              lockout,
   output logic              alarm,
   output logic              relock,
   output logic [FAIL_W-1:0] fail_count
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_OPEN    = 2'd1,
      ST_LOCKOUT = 2'd2
   } state_t;

   // Timer reload values: the window lasts N clocks, counting N-1 down to 0.
   localparam logic [TMR_W-1:0]  OPEN_LOAD  = TMR_W'(OPEN_CYCLES - 1);
   localparam logic [TMR_W-1:0]  LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);
   localparam logic [FAIL_W:0]   FAIL_LIMIT = (FAIL_W + 1)'(MAX_FAILS);

   // Registered state, timer, counter, edge-detect history and outputs.
   state_t              r_state;
   logic [TMR_W-1:0]    r_timer;
   logic [FAIL_W-1:0]   r_fail_count;
   logic                r_unlock_q;
   logic                r_err_q;
   logic                r_relay;
   logic                r_lockout;
   logic                r_alarm;
   logic                r_relock;

   // Next-state values produced by the combinational process.
   state_t              w_state_nxt;
   logic [TMR_W-1:0]    w_timer_nxt;
   logic [FAIL_W-1:0]   w_fail_nxt;
   logic                w_relay_nxt;
   logic                w_lockout_nxt;
   logic                w_alarm_nxt;
   logic                w_relock_nxt;

   // Event detection: only a fresh rising edge of a flag acts.
   logic                w_unlock_ev;
   logic                w_err_ev;
   logic [FAIL_W:0]     w_fail_inc;   // one bit wider so the limit compare cannot wrap

   assign w_unlock_ev = unlock & ~r_unlock_q;
   assign w_err_ev    = err & ~r_err_q;
   assign w_fail_inc  = {1'b0, r_fail_count} + (FAIL_W + 1)'(1);

   // State register, timer, counter, edge history and registered outputs.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_timer      <= '0;
         r_fail_count <= '0;
         r_unlock_q   <= 1'b0;
         r_err_q      <= 1'b0;
         r_relay      <= 1'b0;
         r_lockout    <= 1'b0;
         r_alarm      <= 1'b0;
         r_relock     <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_fail_count <= w_fail_nxt;
         r_unlock_q   <= unlock;
         r_err_q      <= err;
         r_relay      <= w_relay_nxt;
         r_lockout    <= w_lockout_nxt;
         r_alarm      <= w_alarm_nxt;
         r_relock     <= w_relock_nxt;
      end
   end

   // Next-state, timer, counter and next-output decode.
   // Outputs are computed for the state being entered, so they appear one
   // clock after the triggering event with no combinational path to ports.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      w_state_nxt   = r_state;
      w_timer_nxt   = r_timer;
      w_fail_nxt    = r_fail_count;
      w_relay_nxt   = 1'b0;
      w_lockout_nxt = 1'b0;
      w_alarm_nxt   = 1'b0;
      w_relock_nxt  = 1'b0;

      case (r_state)
         ST_IDLE: begin
            if (w_unlock_ev) begin
               // Unlock wins over a simultaneous error; the error is dropped.
               w_state_nxt = ST_OPEN;
               w_timer_nxt = OPEN_LOAD;
               w_fail_nxt  = '0;
               w_relay_nxt = 1'b1;
            end else if (w_err_ev) begin
               w_fail_nxt = w_fail_inc[FAIL_W-1:0];
               if (w_fail_inc < FAIL_LIMIT) begin
                  // Failure below the limit: one relock pulse resets the padlock.
                  w_relock_nxt = 1'b1;
               end else begin
                  w_state_nxt   = ST_LOCKOUT;
                  w_timer_nxt   = LOCK_LOAD;
                  w_lockout_nxt = 1'b1;
                  w_alarm_nxt   = 1'b1;
                  w_relock_nxt  = 1'b1;
               end
            end
         end

         ST_OPEN: begin
            // Events are ignored while the door is open.
            if (r_timer == '0) begin
               w_state_nxt  = ST_IDLE;
               w_relock_nxt = 1'b1;
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
               w_relay_nxt = 1'b1;
            end
         end

         ST_LOCKOUT: begin
            // Relock stays high for the whole window, holding the padlock in reset.
            if (r_timer == '0) begin
               w_state_nxt = ST_IDLE;
               w_fail_nxt  = '0;
            end else begin
               w_timer_nxt   = r_timer - TMR_W'(1);
               w_lockout_nxt = 1'b1;
               w_alarm_nxt   = 1'b1;
               w_relock_nxt  = 1'b1;
            end
         end

         default: begin
            // Unused encoding: return to IDLE with every output cleared.
            w_state_nxt = ST_IDLE;
            w_timer_nxt = '0;
            w_fail_nxt  = '0;
         end
      endcase
   end

   assign relay      = r_relay;
   assign lockout    = r_lockout;
   assign alarm      = r_alarm;
   assign relock     = r_relock;
   assign fail_count = r_fail_count;

endmodule

// File: tb/tb_lock_supervisor.sv
// Directed testbench for lock_supervisor with hand-computed expectations
// (OPEN_CYCLES=8, LOCKOUT_CYCLES=16, MAX_FAILS=3).
module tb_lock_supervisor;

   logic       clk;
   logic       reset;
   logic       unlock;
   logic       err;
   logic       relay;
   logic       lockout;
   logic       alarm;
   logic       relock;
   logic [1:0] fail_count;

   int errors = 0;
   int checks = 0;

   lock_supervisor #(
      .OPEN_CYCLES    (8),
      .LOCKOUT_CYCLES (16),
      .MAX_FAILS      (3),
      .TMR_W          (8),
      .FAIL_W         (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .unlock     (unlock),
      .err        (err),
      .relay      (relay),
      .lockout    (lockout),
      .alarm      (alarm),
      .relock     (relock),
      .fail_count (fail_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n rising edges, then settle 2 time units past the edge.
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic e_relay, input logic e_lockout,
                            input logic e_alarm, input logic e_relock, input logic [1:0] e_fail);
      check({tag, ".relay"},      32'(relay),      32'(e_relay));
      check({tag, ".lockout"},    32'(lockout),    32'(e_lockout));
      check({tag, ".alarm"},      32'(alarm),      32'(e_alarm));
      check({tag, ".relock"},     32'(relock),     32'(e_relock));
      check({tag, ".fail_count"}, 32'(fail_count), 32'(e_fail));
   endtask

   initial begin
      reset  = 1'b1;
      unlock = 1'b0;
      err    = 1'b0;
      tick(3);
      check_all("reset_hold", 0, 0, 0, 0, 2'd0);
      reset = 1'b0;
      tick(2);
      check_all("idle_after_reset", 0, 0, 0, 0, 2'd0);

      // Unlock: relay for exactly 8 clocks, then one relock pulse.
      unlock = 1'b1;
      tick(1);
      check_all("open_k", 1, 0, 0, 0, 2'd0);
      unlock = 1'b0;
      for (int j = 1; j <= 7; j++) begin
         tick(1);
         check($sformatf("open_k+%0d.relay", j), 32'(relay), 32'd1);
      end
      tick(1);
      check_all("open_end", 0, 0, 0, 1, 2'd0);
      tick(1);
      check_all("open_after", 0, 0, 0, 0, 2'd0);

      // Two failures below the limit.
      tick(3);
      err = 1'b1;
      tick(1);
      check_all("err1", 0, 0, 0, 1, 2'd1);
      err = 1'b0;
      tick(1);
      check_all("err1_after", 0, 0, 0, 0, 2'd1);
      tick(5);
      err = 1'b1;
      tick(1);
      check_all("err2", 0, 0, 0, 1, 2'd2);
      err = 1'b0;
      tick(1);
      check_all("err2_after", 0, 0, 0, 0, 2'd2);

      // Third failure: 16-clock lockout, unlock pulse inside is ignored.
      tick(3);
      err = 1'b1;
      tick(1);
      check_all("lock_k", 0, 1, 1, 1, 2'd3);
      err = 1'b0;
      for (int j = 1; j <= 15; j++) begin
         unlock = (j == 5);
         tick(1);
         check($sformatf("lock_k+%0d.lockout", j), 32'(lockout), 32'd1);
         check($sformatf("lock_k+%0d.relay", j),   32'(relay),   32'd0);
      end
      unlock = 1'b0;
      tick(1);
      check_all("lock_end", 0, 0, 0, 0, 2'd0);
      tick(1);
      check_all("lock_after", 0, 0, 0, 0, 2'd0);

      // Simultaneous unlock and err with fail_count = 2: unlock wins.
      err = 1'b1;
      tick(1);
      err = 1'b0;
      tick(1);
      err = 1'b1;
      tick(1);
      err = 1'b0;
      tick(1);
      check_all("pre_simul", 0, 0, 0, 0, 2'd2);
      unlock = 1'b1;
      err    = 1'b1;
      tick(1);
      check_all("simul", 1, 0, 0, 0, 2'd0);
      unlock = 1'b0;
      err    = 1'b0;
      tick(7);
      check_all("simul_open_last", 1, 0, 0, 0, 2'd0);
      tick(1);
      check_all("simul_open_end", 0, 0, 0, 1, 2'd0);
      tick(1);

      // err held high for 20 cycles counts once.
      err = 1'b1;
      tick(1);
      check_all("err_held_first", 0, 0, 0, 1, 2'd1);
      for (int j = 1; j < 20; j++) begin
         tick(1);
         check($sformatf("err_held_%0d.relock", j), 32'(relock), 32'd0);
      end
      check("err_held.fail_count", 32'(fail_count), 32'd1);
      err = 1'b0;
      tick(1);

      // err pulses during OPEN are not counted.
      unlock = 1'b1;
      tick(1);
      unlock = 1'b0;
      check_all("open2", 1, 0, 0, 0, 2'd0);
      for (int j = 0; j < 3; j++) begin
         err = 1'b1;
         tick(1);
         err = 1'b0;
         tick(1);
      end
      check_all("open2_errs", 1, 0, 0, 0, 2'd0);
      tick(2);
      check_all("open2_end", 0, 0, 0, 1, 2'd0);

      // Back-to-back: err rising in the first IDLE cycle is accepted.
      err = 1'b1;
      tick(1);
      check_all("b2b_err", 0, 0, 0, 1, 2'd1);
      err = 1'b0;
      tick(1);
      check_all("b2b_after", 0, 0, 0, 0, 2'd1);

      // Asynchronous reset between edges clears fail_count at once.
      #2;
      reset = 1'b1;
      #1;
      check_all("areset_idle", 0, 0, 0, 0, 2'd0);
      tick(1);
      reset = 1'b0;
      tick(1);

      // Asynchronous reset mid-OPEN drops relay immediately.
      unlock = 1'b1;
      tick(1);
      unlock = 1'b0;
      tick(2);
      check("mid_open.relay", 32'(relay), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check_all("areset_open", 0, 0, 0, 0, 2'd0);
      tick(1);
      reset = 1'b0;
      tick(10);
      check_all("post_reset_quiet", 0, 0, 0, 0, 2'd0);
      unlock = 1'b1;
      tick(1);
      unlock = 1'b0;
      check_all("post_reset_unlock", 1, 0, 0, 0, 2'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
